// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single-port data memory, with lock
// ownership for read-modify-write sequences and a watchdog on held locks.
module mem_port_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int LOCK_MAX = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          r0_req,
   input  logic          r0_we,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_wdata,
   input  logic          r0_lock,
   output logic          r0_gnt,
   output logic          r0_rvalid,
   output logic [DW-1:0] r0_rdata,
   input  logic          r1_req,
   input  logic          r1_we,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_wdata,
   input  logic          r1_lock,
   output logic          r1_gnt,
   output logic          r1_rvalid,
   output logic [DW-1:0] r1_rdata,
   output logic          mem_w_en,
   output logic [AW-1:0] mem_w_addr,
   output logic [DW-1:0] mem_w_data,
   output logic          mem_r_en,
   output logic [AW-1:0] mem_r_addr,
   input  logic [DW-1:0] mem_r_data,
   output logic          lock_err
);

   typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

   localparam logic [7:0] LOCK_MAX_W = 8'(LOCK_MAX);

   state_t        state_q, state_d;
   logic          rr_last_q, rr_last_d;
   logic [7:0]    wd_q, wd_d;
   logic [7:0]    wd_inc;
   logic          r0_rvalid_q, r0_rvalid_d;
   logic          r1_rvalid_q, r1_rvalid_d;
   logic [DW-1:0] r0_rdata_q, r0_rdata_d;
   logic [DW-1:0] r1_rdata_q, r1_rdata_d;

   logic          xfer;
   logic          win;
   logic          win_we;
   logic          win_lock;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_wdata;

   // NOTE: every signal written in an always_comb gets a default on entry, so
   // no path through the case statements can leave it unassigned (no latch).
   always_comb begin
      r0_gnt = 1'b0;
      r1_gnt = 1'b0;
      unique case (state_q)
         ARB: begin
            if (r0_req && r1_req) begin
               r0_gnt = rr_last_q;
               r1_gnt = !rr_last_q;
            end else begin
               r0_gnt = r0_req;
               r1_gnt = r1_req;
            end
         end
         LOCK0:   r0_gnt = r0_req;
         LOCK1:   r1_gnt = r1_req;
         default: ;
      endcase
   end

   assign xfer      = r0_gnt | r1_gnt;
   assign win       = r1_gnt;
   assign win_we    = win ? r1_we    : r0_we;
   assign win_lock  = win ? r1_lock  : r0_lock;
   assign win_addr  = win ? r1_addr  : r0_addr;
   assign win_wdata = win ? r1_wdata : r0_wdata;

   assign mem_w_en   = xfer & win_we;
   assign mem_r_en   = xfer & !win_we;
   assign mem_w_addr = xfer ? win_addr  : '0;
   assign mem_r_addr = xfer ? win_addr  : '0;
   assign mem_w_data = xfer ? win_wdata : '0;

   assign wd_inc = (wd_q == 8'hFF) ? wd_q : wd_q + 8'd1;

   // lock_err is raised on the idle cycle that brings the count to LOCK_MAX, so
   // the owner holds at most LOCK_MAX idle cycles and the stalled side wins next.
   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      wd_d      = wd_q;
      lock_err  = 1'b0;
      unique case (state_q)
         ARB: begin
            wd_d = 8'd0;
            if (xfer) begin
               rr_last_d = win;
               if (win_lock) state_d = win ? LOCK1 : LOCK0;
            end
         end
         LOCK0, LOCK1: begin
            if (xfer) begin
               rr_last_d = win;
               wd_d      = 8'd0;
               if (!win_lock) state_d = ARB;
            end else if (wd_inc >= LOCK_MAX_W) begin
               state_d  = ARB;
               wd_d     = 8'd0;
               lock_err = 1'b1;
            end else begin
               wd_d = wd_inc;
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_comb begin
      r0_rvalid_d = r0_gnt & !r0_we;
      r1_rvalid_d = r1_gnt & !r1_we;
      r0_rdata_d  = r0_rvalid_d ? mem_r_data : r0_rdata_q;
      r1_rdata_d  = r1_rvalid_d ? mem_r_data : r1_rdata_q;
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ARB;
         rr_last_q   <= 1'b1;
         wd_q        <= 8'd0;
         r0_rvalid_q <= 1'b0;
         r1_rvalid_q <= 1'b0;
         r0_rdata_q  <= '0;
         r1_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_last_q   <= rr_last_d;
         wd_q        <= wd_d;
         r0_rvalid_q <= r0_rvalid_d;
         r1_rvalid_q <= r1_rvalid_d;
         r0_rdata_q  <= r0_rdata_d;
         r1_rdata_q  <= r1_rdata_d;
      end
   end

   assign r0_rvalid = r0_rvalid_q;
   assign r1_rvalid = r1_rvalid_q;
   assign r0_rdata  = r0_rdata_q;
   assign r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues the expected per-cycle
// output picture, a negedge monitor pops and compares whenever the DUT is active.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic       req;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic       lock;
   } rq_t;

   typedef struct packed {
      logic       g0, g1, v0, v1;
      logic [7:0] d0, d1;
      logic       w_en, r_en;
      logic [7:0] waddr, raddr, wdata;
      logic       lerr;
   } ev_t;

   typedef struct {
      int  cyc;
      ev_t ev;
   } sb_t;

   localparam rq_t NONE = '0;
   localparam ev_t IDLE = '0;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       r0_req = 1'b0, r0_we = 1'b0, r0_lock = 1'b0;
   logic [7:0] r0_addr = '0, r0_wdata = '0;
   logic       r1_req = 1'b0, r1_we = 1'b0, r1_lock = 1'b0;
   logic [7:0] r1_addr = '0, r1_wdata = '0;
   logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
   logic [7:0] r0_rdata, r1_rdata;
   logic       mem_w_en, mem_r_en, lock_err;
   logic [7:0] mem_w_addr, mem_w_data, mem_r_addr, mem_r_data;

   logic [7:0] mem_model [256];
   int         cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   sb_t        sb_q[$];

   mem_port_arbiter #(.AW(8), .DW(8), .LOCK_MAX(15)) dut (
      .clk(clk), .rst(rst),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_lock(r0_lock), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_lock(r1_lock), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
      .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
      .lock_err(lock_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: preloaded with ~addr, combinational read, synchronous write.
   initial for (int i = 0; i < 256; i++) mem_model[i] = ~8'(i);
   always @(posedge clk) if (mem_w_en) mem_model[mem_w_addr] <= mem_w_data;
   assign mem_r_data = mem_model[mem_r_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic rq_t rd(input logic [7:0] a, input logic l);
      rq_t r;
      r = '0;
      r.req = 1'b1; r.addr = a; r.lock = l;
      return r;
   endfunction

   function automatic rq_t wr(input logic [7:0] a, input logic [7:0] d, input logic l);
      rq_t r;
      r = '0;
      r.req = 1'b1; r.we = 1'b1; r.addr = a; r.wdata = d; r.lock = l;
      return r;
   endfunction

   function automatic ev_t xf(input logic who, input logic we,
                              input logic [7:0] a, input logic [7:0] d);
      ev_t e;
      e = '0;
      if (who) e.g1 = 1'b1; else e.g0 = 1'b1;
      e.w_en = we; e.r_en = !we; e.waddr = a; e.raddr = a; e.wdata = d;
      return e;
   endfunction

   function automatic ev_t rv(input ev_t base, input logic who, input logic [7:0] d);
      ev_t e;
      e = base;
      if (who) begin e.v1 = 1'b1; e.d1 = d; end
      else     begin e.v0 = 1'b1; e.d0 = d; end
      return e;
   endfunction

   task automatic drive(input rq_t a, input rq_t b);
      r0_req = a.req; r0_we = a.we; r0_addr = a.addr; r0_wdata = a.wdata; r0_lock = a.lock;
      r1_req = b.req; r1_we = b.we; r1_addr = b.addr; r1_wdata = b.wdata; r1_lock = b.lock;
   endtask

   task automatic expect_ev(input ev_t e);
      sb_t s;
      if (e != IDLE) begin
         s.cyc = cyc;
         s.ev  = e;
         sb_q.push_back(s);
      end
   endtask

   task automatic step(input rq_t a, input rq_t b, input ev_t e);
      drive(a, b);
      expect_ev(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares the full output picture on every active cycle.
   always @(negedge clk) begin
      ev_t act;
      sb_t s;
      act       = '0;
      act.g0    = r0_gnt;
      act.g1    = r1_gnt;
      act.v0    = r0_rvalid;
      act.v1    = r1_rvalid;
      act.d0    = r0_rvalid ? r0_rdata : 8'h00;
      act.d1    = r1_rvalid ? r1_rdata : 8'h00;
      act.w_en  = mem_w_en;
      act.r_en  = mem_r_en;
      act.waddr = mem_w_addr;
      act.raddr = mem_r_addr;
      act.wdata = mem_w_data;
      act.lerr  = lock_err;
      vectors++;
      if (act != IDLE) begin
         if (sb_q.size() == 0 || sb_q[0].cyc > cyc) begin
            miscompares++;
            $display("FAIL unexpected_activity cyc %0d: got %h, want none", cyc, act);
         end else begin
            s = sb_q.pop_front();
            if (s.cyc != cyc || s.ev != act) begin
               miscompares++;
               $display("FAIL event cyc %0d (exp cyc %0d): got %h, want %h",
                        cyc, s.cyc, act, s.ev);
            end
         end
      end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         s = sb_q.pop_front();
         miscompares++;
         $display("FAIL missing_event cyc %0d: got %h, want %h", cyc, act, s.ev);
      end else if ({mem_w_addr, mem_r_addr, mem_w_data} != 24'h0) begin
         miscompares++;
         $display("FAIL idle_mem_bus cyc %0d: got %h, want 000000", cyc,
                  {mem_w_addr, mem_r_addr, mem_w_data});
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      drive(NONE, NONE);
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {23'd0, r0_rvalid, r1_rvalid, lock_err, 6'd0},
            32'h0);
      check("reset_rdata", {16'd0, r0_rdata, r1_rdata}, 32'h0);
      rst = 1'b1;

      // Single write, then read-back with latency 1.
      step(wr(8'h10, 8'hA5, 1'b0), NONE, xf(1'b0, 1'b1, 8'h10, 8'hA5));
      step(rd(8'h10, 1'b0), NONE, xf(1'b0, 1'b0, 8'h10, 8'h00));
      step(NONE, NONE, rv(IDLE, 1'b0, 8'hA5));
      step(NONE, wr(8'h40, 8'h77, 1'b0), xf(1'b1, 1'b1, 8'h40, 8'h77));

      // Both requesting reads: grants alternate r0, r1, r0, r1.
      step(rd(8'h30, 1'b0), rd(8'h31, 1'b0), xf(1'b0, 1'b0, 8'h30, 8'h00));
      step(rd(8'h32, 1'b0), rd(8'h31, 1'b0), rv(xf(1'b1, 1'b0, 8'h31, 8'h00), 1'b0, 8'hCF));
      step(rd(8'h32, 1'b0), rd(8'h33, 1'b0), rv(xf(1'b0, 1'b0, 8'h32, 8'h00), 1'b1, 8'hCE));
      step(rd(8'h34, 1'b0), rd(8'h33, 1'b0), rv(xf(1'b1, 1'b0, 8'h33, 8'h00), 1'b0, 8'hCD));
      step(NONE, NONE, rv(IDLE, 1'b1, 8'hCC));

      // r1 locked sequence with r0 stalled throughout; back-to-back locked transfers.
      step(NONE, rd(8'h20, 1'b1), xf(1'b1, 1'b0, 8'h20, 8'h00));
      step(rd(8'h50, 1'b0), NONE, rv(IDLE, 1'b1, 8'hDF));
      step(rd(8'h50, 1'b0), NONE, IDLE);
      step(rd(8'h50, 1'b0), wr(8'h20, 8'hE0, 1'b1), xf(1'b1, 1'b1, 8'h20, 8'hE0));
      step(rd(8'h50, 1'b0), rd(8'h21, 1'b0), xf(1'b1, 1'b0, 8'h21, 8'h00));
      step(rd(8'h50, 1'b0), NONE, rv(xf(1'b0, 1'b0, 8'h50, 8'h00), 1'b1, 8'hDE));
      step(NONE, NONE, rv(IDLE, 1'b0, 8'hAF));

      // Watchdog: r0 locks then idles; lock_err on the 15th idle cycle.
      step(wr(8'h60, 8'h11, 1'b1), NONE, xf(1'b0, 1'b1, 8'h60, 8'h11));
      repeat (14) step(NONE, rd(8'h61, 1'b0), IDLE);
      begin
         ev_t e;
         e = IDLE;
         e.lerr = 1'b1;
         step(NONE, rd(8'h61, 1'b0), e);
      end
      step(NONE, rd(8'h61, 1'b0), xf(1'b1, 1'b0, 8'h61, 8'h00));
      step(NONE, NONE, rv(IDLE, 1'b1, 8'h9E));

      // Reset hits while an r1 read is in flight.
      drive(NONE, rd(8'h70, 1'b0));
      expect_ev(xf(1'b1, 1'b0, 8'h70, 8'h00));
      @(negedge clk);
      #1;
      rst = 1'b0;
      drive(NONE, NONE);
      #1;
      check("async_reset_rvalid_lerr", {29'd0, r0_rvalid, r1_rvalid, lock_err}, 32'h0);
      check("async_reset_rdata", {16'd0, r0_rdata, r1_rdata}, 32'h0);
      check("async_reset_mem", {7'd0, mem_w_en, mem_r_en, mem_w_addr, mem_r_addr, 1'b0}, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // First tie after reset goes to r0.
      step(rd(8'h80, 1'b0), rd(8'h81, 1'b0), xf(1'b0, 1'b0, 8'h80, 8'h00));
      step(NONE, rd(8'h81, 1'b0), rv(xf(1'b1, 1'b0, 8'h81, 8'h00), 1'b0, 8'h7F));
      step(NONE, NONE, rv(IDLE, 1'b1, 8'h7E));

      // Quiet period: no grants, memory bus held at zero.
      repeat (10) step(NONE, NONE, IDLE);

      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
